// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. A request (op, A, B) is
// accepted over a valid/ready handshake, its operands are registered and
// presented to the ALU for one execute cycle, and the captured result and zero
// flag are returned to the owning requester over a second valid/ready
// handshake. One operation is in flight at a time (IDLE -> EXEC -> RESP).
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  defined   : round-robin tie-break using a
//                                       last-grant register (requester 0 wins
//                                       the first tie after reset).
//                           undefined : fixed priority, requester 0 wins ties.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid_n_i/req_ready_n_o request handshake for requester n (n = 0, 1)
//   req_op_n_i, req_a_n_i,
//   req_b_n_i                   request payload (held stable until accepted)
//   rsp_valid_n_o/rsp_ready_n_i response handshake for requester n
//   rsp_result_o, rsp_zero_o    captured ALU result / zero flag (shared bus)
//   alu_op_o, alu_a_o, alu_b_o  registered operands to the ALU
//   alu_result_i, alu_zero_i    ALU outputs, captured at the end of EXEC
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid_0_i,
  output logic                  req_ready_0_o,
  input  logic [OP_WIDTH-1:0]   req_op_0_i,
  input  logic [DATA_WIDTH-1:0] req_a_0_i,
  input  logic [DATA_WIDTH-1:0] req_b_0_i,

  input  logic                  req_valid_1_i,
  output logic                  req_ready_1_o,
  input  logic [OP_WIDTH-1:0]   req_op_1_i,
  input  logic [DATA_WIDTH-1:0] req_a_1_i,
  input  logic [DATA_WIDTH-1:0] req_b_1_i,

  output logic                  rsp_valid_0_o,
  input  logic                  rsp_ready_0_i,
  output logic                  rsp_valid_1_o,
  input  logic                  rsp_ready_1_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  rsp_zero_o,

  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  owner_q;
  logic                  rsp_valid_0_q;
  logic                  rsp_valid_1_q;

  logic                  prefer_0;
  logic                  grant_0;
  logic                  grant_1;
  logic                  accept;
  logic                  owner_d;
  logic                  rsp_hs;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Requester that won the most recent accept; resets to 1 so that
  // requester 0 takes the first tie.
  logic last_q;
  assign prefer_0 = last_q;
`else
  assign prefer_0 = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb is given a value on every
  // path; a missed branch would otherwise infer a latch.
  always_comb begin
    grant_0 = req_valid_0_i & (~req_valid_1_i | prefer_0);
    grant_1 = req_valid_1_i & ~grant_0;
  end

  // Ready is purely a function of the request valids and the current state;
  // it is forced low while reset is asserted so nothing is accepted then.
  assign req_ready_0_o = (state_q == IDLE) & ~reset & grant_0;
  assign req_ready_1_o = (state_q == IDLE) & ~reset & grant_1;

  // A ready is only raised for a valid requester, so ready alone marks an
  // accept, and the ready of requester 1 identifies the new owner.
  assign accept  = req_ready_0_o | req_ready_1_o;
  assign owner_d = req_ready_1_o;

  // Only the owner's rsp_ready can complete the response.
  assign rsp_hs = owner_q ? rsp_ready_1_i : rsp_ready_0_i;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      owner_q       <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q        <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= owner_d ? req_op_1_i : req_op_0_i;
            a_q     <= owner_d ? req_a_1_i  : req_a_0_i;
            b_q     <= owner_d ? req_b_1_i  : req_b_0_i;
            owner_q <= owner_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q  <= owner_d;
`endif
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been on the ALU for a full cycle; capture its
          // outputs and raise the owner's response valid together.
          result_q      <= alu_result_i;
          zero_q        <= alu_zero_i;
          rsp_valid_0_q <= ~owner_q;
          rsp_valid_1_q <= owner_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ALU operands come straight from the operand registers and therefore
  // hold the last accepted request outside EXEC.
  assign alu_op_o      = op_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign rsp_result_o  = result_q;
  assign rsp_zero_o    = zero_q;
  assign rsp_valid_0_o = rsp_valid_0_q;
  assign rsp_valid_1_o = rsp_valid_1_q;

endmodule
